fp_mul_pipe: RTL and testbench



---
 rtl/fp_mul_pipe_if.sv | 30 +++
 rtl/fp_mul_pipe.sv | 138 +++++++++++++
 tb/tb_fp_mul_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The master drives operands and out_ready; the slave (the multiplier) returns in_ready and the product.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic             in_valid;
    logic             in_ready;
    logic             sign_x;
    logic             sign_y;
    logic [EXP_W-1:0] exp_x;
    logic [EXP_W-1:0] exp_y;
    logic [MAN_W-1:0] man_x;
    logic [MAN_W-1:0] man_y;
    logic             out_valid;
    logic             out_ready;
    logic             sign_out;
    logic [EXP_W-1:0] exp_out;
    logic [MAN_W-1:0] man_out;

    modport master (
        output in_valid, sign_x, sign_y, exp_x, exp_y, man_x, man_y, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, man_out
    );

    modport slave (
        input  in_valid, sign_x, sign_y, exp_x, exp_y, man_x, man_y, out_ready,
        output in_ready, out_valid, sign_out, exp_out, man_out
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage elastic floating-point multiplier (truncating, saturating, no denormals/Inf/NaN).
// Define FP_MUL_STATUS_EN to add ovf_flag/unf_flag outputs and the saturating sat_count counter.
module fp_mul_pipe #(
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int APPROX_BITS = 0
) (
    input  logic          clk,
    input  logic          rst,
    fp_mul_pipe_if.slave  bus
`ifdef FP_MUL_STATUS_EN
    ,
    output logic          ovf_flag,
    output logic          unf_flag,
    output logic [15:0]   sat_count
`endif
);
    localparam int PW = 2*MAN_W + 2;
    localparam int HW = MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int RW = 2 + EXP_W + MAN_W;
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W-1)) - 1);
    localparam logic signed [EW-1:0] EXP_OVF = EW'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0]     MAN_MASK = ~(MAN_W'((64'd1 << APPROX_BITS) - 64'd1));

    // Returns {ovf, unf, exp, man}; zero operands override both saturation cases.
    function automatic logic [RW-1:0] norm_sat(input logic zero,
                                               input logic signed [EW-1:0] e_sum,
                                               input logic [HW-1:0] prod_hi);
        logic signed [EW-1:0] e;
        logic [MAN_W-1:0]     m;
        e = e_sum + $signed({{(EW-1){1'b0}}, prod_hi[HW-1]});
        m = prod_hi[HW-1] ? prod_hi[HW-2:1] : prod_hi[HW-3:0];
        if (zero)
            return RW'(0);
        else if (e >= EXP_OVF)
            return {2'b10, EXP_W'((1 << EXP_W) - 2), {MAN_W{1'b1}}};
        else if (e <= 0)
            return {2'b01, EXP_W'(1), {MAN_W{1'b0}}};
        else
            return {2'b00, e[EXP_W-1:0], m};
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic load_p0, load_p1, load_p2;

    logic             sign_p0, zero_p0;
    logic [EXP_W-1:0] exp_x_p0, exp_y_p0;
    logic [MAN_W-1:0] man_x_p0, man_y_p0;

    logic                 sign_p1, zero_p1;
    logic signed [EW-1:0] esum_p1;
    logic [HW-1:0]        prod_p1;

    logic             sign_p2, ovf_p2, unf_p2;
    logic [EXP_W-1:0] exp_p2;
    logic [MAN_W-1:0] man_p2;

    logic [PW-1:0] prod_full;
    logic          unused_prod_lo;

    // Ready ripples back combinationally so a full pipe can drain and refill in one cycle.
    assign load_p2     = !vld_p2 || bus.out_ready;
    assign load_p1     = !vld_p1 || load_p2;
    assign load_p0     = !vld_p0 || load_p1;
    assign bus.in_ready = load_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (load_p0) vld_p0 <= bus.in_valid;
            if (load_p1) vld_p1 <= vld_p0;
            if (load_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- S1: operand capture, approximation mask, zero detect ----
    always_ff @(posedge clk) begin
        if (load_p0 && bus.in_valid) begin
            sign_p0  <= bus.sign_x ^ bus.sign_y;
            zero_p0  <= (bus.exp_x == '0) || (bus.exp_y == '0);
            exp_x_p0 <= bus.exp_x;
            exp_y_p0 <= bus.exp_y;
            man_x_p0 <= bus.man_x & MAN_MASK;
            man_y_p0 <= bus.man_y & MAN_MASK;
        end
    end

    // ---- S2: mantissa multiply, biased exponent sum ----
    assign prod_full      = PW'({1'b1, man_x_p0}) * PW'({1'b1, man_y_p0});
    assign unused_prod_lo = ^prod_full[PW-HW-1:0];

    always_ff @(posedge clk) begin
        if (load_p1 && vld_p0) begin
            sign_p1 <= sign_p0;
            zero_p1 <= zero_p0;
            esum_p1 <= $signed({2'b00, exp_x_p0}) + $signed({2'b00, exp_y_p0}) - BIAS;
            prod_p1 <= prod_full[PW-1 -: HW];
        end
    end

    // ---- S3: normalise and saturate; these registers drive the outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            unf_p2  <= 1'b0;
            exp_p2  <= '0;
            man_p2  <= '0;
        end else if (load_p2 && vld_p1) begin
            sign_p2 <= sign_p1;
            {ovf_p2, unf_p2, exp_p2, man_p2} <= norm_sat(zero_p1, esum_p1, prod_p1);
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.sign_out  = sign_p2;
    assign bus.exp_out   = exp_p2;
    assign bus.man_out   = man_p2;

`ifdef FP_MUL_STATUS_EN
    assign ovf_flag = ovf_p2;
    assign unf_flag = unf_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (vld_p2 && bus.out_ready && (ovf_p2 || unf_p2) && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
`else
    logic unused_flags;
    assign unused_flags = ovf_p2 ^ unf_p2;
`endif
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: exact and APPROX_BITS=4 instances share one stimulus stream.
// Status-port checks are enabled when FP_MUL_STATUS_EN is defined.
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus_a ();

    assign bus_a.in_valid  = bus.in_valid;
    assign bus_a.sign_x    = bus.sign_x;
    assign bus_a.sign_y    = bus.sign_y;
    assign bus_a.exp_x     = bus.exp_x;
    assign bus_a.exp_y     = bus.exp_y;
    assign bus_a.man_x     = bus.man_x;
    assign bus_a.man_y     = bus.man_y;
    assign bus_a.out_ready = bus.out_ready;

`ifdef FP_MUL_STATUS_EN
    logic        ovf0, unf0, ovf1, unf1;
    logic [15:0] satc0, satc1;
`endif

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .APPROX_BITS(0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
`ifdef FP_MUL_STATUS_EN
        , .ovf_flag(ovf0), .unf_flag(unf0), .sat_count(satc0)
`endif
    );

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .APPROX_BITS(4)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
`ifdef FP_MUL_STATUS_EN
        , .ovf_flag(ovf1), .unf_flag(unf1), .sat_count(satc1)
`endif
    );

    typedef struct {
        logic        sx;
        logic [7:0]  ex;
        logic [22:0] mx;
        logic        sy;
        logic [7:0]  ey;
        logic [22:0] my;
        logic [33:0] expv;
    } vec_t;

    vec_t        vq[$];
    logic [33:0] sb0[$];
    logic [33:0] sb1[$];
    logic [33:0] exp_cur;
    logic [33:0] e0, e1;
    int          n_chk = 0;
    int          n_pass = 0;
    int          acc = 0;
    int          nsat0 = 0;
    int          nsat1 = 0;
    int          cyc;
    bit          done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // Reference: {ovf, unf, sign, exp, man} for 8/23 fields with ab low mantissa bits cleared.
    function automatic logic [33:0] model(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                                          input logic sy, input logic [7:0] ey, input logic [22:0] my,
                                          input int ab);
        logic [22:0] mask;
        logic [63:0] p;
        logic [22:0] m;
        int          e;
        mask = 23'h7FFFFF << ab;
        p = 64'({1'b1, mx & mask}) * 64'({1'b1, my & mask});
        e = int'(ex) + int'(ey) - 127;
        if (p[47]) begin
            e++;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (ex == 8'd0 || ey == 8'd0) return {2'b00, sx ^ sy, 8'd0, 23'd0};
        if (e >= 255)                 return {2'b10, sx ^ sy, 8'd254, 23'h7FFFFF};
        if (e <= 0)                   return {2'b01, sx ^ sy, 8'd1, 23'd0};
        return {2'b00, sx ^ sy, e[7:0], m};
    endfunction

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready && !rst) begin
            sb0.push_back(exp_cur);
            sb1.push_back(model(bus.sign_x, bus.exp_x, bus.man_x, bus.sign_y, bus.exp_y, bus.man_y, 4));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb0.size() == 0) begin
                check("exact_spurious", 64'd1, 64'd0);
            end else begin
                e0 = sb0.pop_front();
                check("exact_result", {bus.sign_out, bus.exp_out, bus.man_out}, e0[31:0]);
`ifdef FP_MUL_STATUS_EN
                check("exact_flags", {ovf0, unf0}, e0[33:32]);
                if (e0[33] || e0[32]) nsat0++;
`endif
            end
        end
        if (bus_a.out_valid && bus_a.out_ready) begin
            if (sb1.size() == 0) begin
                check("approx_spurious", 64'd1, 64'd0);
            end else begin
                e1 = sb1.pop_front();
                check("approx_result", {bus_a.sign_out, bus_a.exp_out, bus_a.man_out}, e1[31:0]);
`ifdef FP_MUL_STATUS_EN
                check("approx_flags", {ovf1, unf1}, e1[33:32]);
                if (e1[33] || e1[32]) nsat1++;
`endif
            end
        end
    end

    task automatic add_vec(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                           input logic sy, input logic [7:0] ey, input logic [22:0] my,
                           input logic [33:0] expv);
        vq.push_back('{sx: sx, ex: ex, mx: mx, sy: sy, ey: ey, my: my, expv: expv});
    endtask

    task automatic add_rand(input int n);
        logic        sx, sy;
        logic [7:0]  ex, ey;
        logic [22:0] mx, my;
        for (int i = 0; i < n; i++) begin
            sx = 1'($urandom_range(0, 1));
            sy = 1'($urandom_range(0, 1));
            ex = 8'($urandom_range(0, 255));
            ey = 8'($urandom_range(0, 255));
            mx = 23'($urandom);
            my = 23'($urandom);
            add_vec(sx, ex, mx, sy, ey, my, model(sx, ex, mx, sy, ey, my, 0));
        end
    endtask

    task automatic run_vecs(input int max_cycles, output int cycles);
        cycles = 0;
        while (vq.size() > 0 && cycles < max_cycles) begin
            bus.sign_x   = vq[0].sx;
            bus.exp_x    = vq[0].ex;
            bus.man_x    = vq[0].mx;
            bus.sign_y   = vq[0].sy;
            bus.exp_y    = vq[0].ey;
            bus.man_y    = vq[0].my;
            exp_cur      = vq[0].expv;
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) begin
                vq.delete(0);
                acc++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb0.size() > 0 || sb1.size() > 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 64'(sb0.size() + sb1.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required self-finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.sign_x = 1'b0; bus.sign_y = 1'b0;
        bus.exp_x  = '0;   bus.exp_y  = '0;
        bus.man_x  = '0;   bus.man_y  = '0;
        exp_cur = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_fields", {bus.sign_out, bus.exp_out, bus.man_out}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1.5 * 1.5 = 2.25 with exact three-cycle latency
        bus.exp_x = 8'd127; bus.man_x = 23'h400000;
        bus.exp_y = 8'd127; bus.man_y = 23'h400000;
        exp_cur = {2'b00, 1'b0, 8'd128, 23'h100000};
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle3", bus.out_valid, 1);
        check("mul_1p5", {bus.sign_out, bus.exp_out, bus.man_out}, {1'b0, 8'd128, 23'h100000});
        @(posedge clk);
        #1;

        add_vec(0, 8'd200, 23'h0,      0, 8'd200, 23'h0,      {2'b10, 1'b0, 8'd254, 23'h7FFFFF});
        add_vec(0, 8'd191, 23'h0,      0, 8'd191, 23'h0,      {2'b10, 1'b0, 8'd254, 23'h7FFFFF});
        add_vec(0, 8'd190, 23'h0,      0, 8'd191, 23'h0,      {2'b00, 1'b0, 8'd254, 23'h0});
        add_vec(0, 8'd64,  23'h0,      0, 8'd63,  23'h0,      {2'b01, 1'b0, 8'd1,   23'h0});
        add_vec(1, 8'd20,  23'h0,      1, 8'd20,  23'h0,      {2'b01, 1'b0, 8'd1,   23'h0});
        add_vec(0, 8'd64,  23'h0,      0, 8'd64,  23'h0,      {2'b00, 1'b0, 8'd1,   23'h0});
        add_vec(1, 8'd0,   23'h123456, 0, 8'd130, 23'h7FFFFF, {2'b00, 1'b1, 8'd0,   23'h0});
        add_vec(0, 8'd255, 23'h5,      1, 8'd0,   23'h0,      {2'b00, 1'b1, 8'd0,   23'h0});
        add_vec(0, 8'd127, 23'h0,      1, 8'd128, 23'h0,      {2'b00, 1'b1, 8'd128, 23'h0});
        add_vec(1, 8'd128, 23'h600000, 1, 8'd126, 23'h200000, {2'b00, 1'b0, 8'd128, 23'h0C0000});
        run_vecs(100, cyc);
        wait_drain();

        // Back-to-back random stream, one accept per cycle
        add_rand(20);
        run_vecs(100, cyc);
        check("throughput_cycles", cyc, 20);
        wait_drain();

        // Full pipe under backpressure
        bus.out_ready = 1'b0;
        acc = 0;
        add_rand(5);
        run_vecs(6, cyc);
        check("bp_accepts", acc, 3);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        run_vecs(50, cyc);
        check("bp_total", acc, 5);
        wait_drain();

        // Random output stalls
        add_rand(40);
        done = 1'b0;
        fork
            begin
                run_vecs(600, cyc);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        check("stall_left", vq.size(), 0);
        bus.out_ready = 1'b1;
        wait_drain();

`ifdef FP_MUL_STATUS_EN
        check("sat_count_exact", satc0, 64'(nsat0));
        check("sat_count_approx", satc1, 64'(nsat1));
`endif

        // Reset with three results in flight
        bus.out_ready = 1'b0;
        acc = 0;
        add_rand(3);
        run_vecs(3, cyc);
        check("rst_inflight", acc, 3);
        check("rst_pre_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_valid_a", bus_a.out_valid, 0);
        check("rst_async_ready", bus.in_ready, 1);
        check("rst_async_fields", {bus.sign_out, bus.exp_out, bus.man_out}, 0);
        sb0.delete();
        sb1.delete();
        nsat0 = 0;
        nsat1 = 0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        add_vec(0, 8'd127, 23'h0, 1, 8'd128, 23'h0, {2'b00, 1'b1, 8'd128, 23'h0});
        add_rand(4);
        run_vecs(50, cyc);
        wait_drain();
`ifdef FP_MUL_STATUS_EN
        check("sat_count_after_rst", satc0, 64'(nsat0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
